shift_reg_engine: RTL

Parametrised-width shift register with parallel load, selectable direction and fill mode, and an autonomous multi-bit shift engine. A single Start pulse runs Count shifts back to back and reports completion with Busy and Done. Used wherever serial or bit-stream data is packed or unpacked, such as sprite/pixel row serialisation and controller data. It supersedes the fixed 24-bit right-shift register, which also shifted only 8 bits of its width.

---
 rtl/shift_reg_engine.sv | 124 ++++++++++++
 1 files changed

// File: rtl/shift_reg_engine.sv
// shift_reg_engine
//   Parametrised shift register with parallel load, selectable direction and
//   fill mode, and an autonomous engine that runs Count shifts from a single
//   Start pulse.
//
// Ports
//   Clk        clock, all state on rising edge
//   Reset      synchronous, active-high reset
//   Load       parallel load of D (aborts a run in progress, no Done)
//   D          parallel load data
//   Shift_En   manual single shift, honoured only while idle
//   Dir        0 = shift right (toward bit 0), 1 = shift left
//   Mode       00 serial fill, 01 rotate, 10 arithmetic, 11 zero fill
//   Shift_In   serial input bit for Mode 00
//   Start      begin an auto run of Count shifts (ignored while Busy)
//   Count      number of shifts for the auto run
//   Busy       auto run in progress
//   Done       one-cycle pulse when an auto run completes
//   Shift_Out  bit that exits on the next shift
//   Data_Out   register contents
module shift_reg_engine #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic             Dir,
  input  logic [1:0]       Mode,
  input  logic             Shift_In,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Shift_Out,
  output logic [WIDTH-1:0] Data_Out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic             done_q;

  // One shift step. Arithmetic mode only sign-extends when shifting right;
  // shifting left it behaves like zero fill.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] cur,
    input logic             dir,
    input logic [1:0]       mode,
    input logic             sin
  );
    logic fill;
    fill = 1'b0;
    if (!dir) begin
      case (mode)
        2'b00:   fill = sin;
        2'b01:   fill = cur[0];
        2'b10:   fill = cur[WIDTH-1];
        default: fill = 1'b0;
      endcase
      shift_step = {fill, cur[WIDTH-1:1]};
    end else begin
      case (mode)
        2'b00:   fill = sin;
        2'b01:   fill = cur[WIDTH-1];
        default: fill = 1'b0;
      endcase
      shift_step = {cur[WIDTH-2:0], fill};
    end
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      data_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (Load) begin
        // Load overrides everything and silently aborts any run.
        data_q <= D;
        state  <= IDLE;
        cnt_q  <= '0;
      end else if (state == IDLE && Start) begin
        if (Count != '0) begin
          dir_q  <= Dir;
          mode_q <= Mode;
          cnt_q  <= Count;
          state  <= RUN;
        end else begin
          done_q <= 1'b1;
        end
      end else if (state == RUN) begin
        data_q <= shift_step(data_q, dir_q, mode_q, Shift_In);
        cnt_q  <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
      end else if (Shift_En) begin
        data_q <= shift_step(data_q, Dir, Mode, Shift_In);
      end
    end
  end

  assign Busy      = (state == RUN);
  assign Done      = done_q;
  assign Data_Out  = data_q;
  // During a run the exiting bit follows the latched direction.
  assign Shift_Out = ((state == RUN) ? dir_q : Dir) ? data_q[WIDTH-1] : data_q[0];

endmodule
